// File: rtl/tlp_pkg.sv
// Shared types and constants for the TLP egress dispatcher.
package tlp_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned ID_W   = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

endpackage

// File: rtl/tlp_dispatch_if.sv
// Link-side input stream and the four per-channel egress streams of the dispatcher.
interface tlp_dispatch_if
  import tlp_pkg::*;
#(
  parameter int unsigned DATA_W = 32
);

  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic [ID_W-1:0]          in_id;
  logic                     in_last;
  logic                     in_ready;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_last;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH-1:0]        pkt_done;
  logic                     err_switch;

  modport master (
    output in_valid, in_data, in_id, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, pkt_done, err_switch
  );

  modport slave (
    input  in_valid, in_data, in_id, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, pkt_done, err_switch
  );

endinterface

// File: rtl/tlp_chan_fifo.sv
// Per-channel first-word-fall-through FIFO; MSB of each entry is the end-of-TLP flag.
module tlp_chan_fifo #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  output logic         full,
  input  logic         pop_ready,
  output logic         rvalid,
  output logic [W-1:0] rdata,
  output logic         done
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_en;
  logic             rd_en;

  // Push is refused while full even if a pop happens in the same cycle.
  assign full   = (count == CNT_W'(DEPTH));
  assign rvalid = (count != '0);
  assign wr_en  = push & ~full;
  assign rd_en  = rvalid & pop_ready;
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      done   <= 1'b0;
    end else begin
      done <= rd_en & rdata[W-1];
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tlp_dispatch.sv
// Routes whole TLPs from one tagged word stream into four per-channel egress FIFOs.
module tlp_dispatch
  import tlp_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input logic          clk,
  input logic          rst,
  tlp_dispatch_if.slave bus
);

  state_t            state;
  logic [ID_W-1:0]   cur_id;
  logic [ID_W-1:0]   target;
  logic              accept;
  logic              err_q;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] vld;
  logic [NUM_CH-1:0] done;
  logic [DATA_W:0]   rdata [NUM_CH];

  // A TLP's first word picks the channel; later words follow it regardless of in_id.
  assign target       = (state == IN_PKT) ? cur_id : bus.in_id;
  assign bus.in_ready = ~full[target];
  assign accept       = bus.in_valid & ~full[target];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cur_id <= '0;
      err_q  <= 1'b0;
    end else begin
      if ((state == IN_PKT) && bus.in_valid && (bus.in_id != cur_id)) err_q <= 1'b1;
      if (accept) begin
        case (state)
          IDLE: begin
            if (!bus.in_last) begin
              state  <= IN_PKT;
              cur_id <= bus.in_id;
            end
          end
          IN_PKT: begin
            if (bus.in_last) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign push[c] = accept && (target == ID_W'(c));

    tlp_chan_fifo #(
      .W     (DATA_W + 1),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst),
      .push      (push[c]),
      .wdata     ({bus.in_last, bus.in_data}),
      .full      (full[c]),
      .pop_ready (bus.out_ready[c]),
      .rvalid    (vld[c]),
      .rdata     (rdata[c]),
      .done      (done[c])
    );

    assign bus.out_data[c*DATA_W +: DATA_W] = rdata[c][DATA_W-1:0];
    assign bus.out_last[c]                  = rdata[c][DATA_W];
  end

  assign bus.out_valid  = vld;
  assign bus.pkt_done   = done;
  assign bus.err_switch = err_q;

endmodule

// File: tb/tb_tlp_dispatch.sv
// Randomized bench for tlp_dispatch against a queue-per-channel reference model.
module tb_tlp_dispatch;
  import tlp_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tlp_dispatch_if #(.DATA_W(DATA_W)) bus ();

  tlp_dispatch #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: contents of each channel buffer, the channel of the TLP in flight (-1 if none).
  logic [DATA_W:0] mq [4][$];
  int  open_ch;
  bit  err_m;
  bit  exp_done [4];
  int  sent [4];
  int  seen [4];
  bit  rand_rdy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int c = 0; c < 4; c++) begin
      mq[c].delete();
      exp_done[c] = 1'b0;
      sent[c]     = 0;
      seen[c]     = 0;
    end
    open_ch = -1;
    err_m   = 1'b0;
  endfunction

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic step(output bit acc);
    int              tgt;
    bit [3:0]        pop;
    logic [DATA_W:0] fr;
    if (rand_rdy) bus.out_ready = 4'($urandom);
    #1;
    tgt = (open_ch >= 0) ? open_ch : int'(bus.in_id);
    chk("in_ready", 64'(bus.in_ready), 64'(mq[tgt].size() < DEPTH));
    for (int c = 0; c < 4; c++) begin
      chk("out_valid", 64'(bus.out_valid[c]), 64'(mq[c].size() != 0));
      if (mq[c].size() != 0) begin
        fr = mq[c][0];
        chk("out_data", 64'(bus.out_data[c*DATA_W +: DATA_W]), 64'(fr[DATA_W-1:0]));
        chk("out_last", 64'(bus.out_last[c]), 64'(fr[DATA_W]));
      end
      chk("pkt_done", 64'(bus.pkt_done[c]), 64'(exp_done[c]));
      if (bus.pkt_done[c]) seen[c]++;
      pop[c] = (mq[c].size() != 0) && bus.out_ready[c];
    end
    chk("err_switch", 64'(bus.err_switch), 64'(err_m));
    acc = bus.in_valid && (mq[tgt].size() < DEPTH);
    @(posedge clk);
    if (open_ch >= 0 && bus.in_valid && int'(bus.in_id) != open_ch) err_m = 1'b1;
    for (int c = 0; c < 4; c++) begin
      exp_done[c] = 1'b0;
      if (pop[c]) begin
        fr          = mq[c].pop_front();
        exp_done[c] = fr[DATA_W];
      end
    end
    if (acc) begin
      mq[tgt].push_back({bus.in_last, bus.in_data});
      if (bus.in_last) begin
        sent[tgt]++;
        open_ch = -1;
      end else begin
        open_ch = tgt;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    bus.in_valid = 1'b0;
    for (int k = 0; k < n; k++) step(acc);
  endtask

  task automatic send_word(input logic [1:0] id, input logic [DATA_W-1:0] d, input logic last);
    bit acc;
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_id    = id;
    bus.in_data  = d;
    bus.in_last  = last;
    do begin
      step(acc);
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 64'(0), 64'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_pkt_done", 64'(bus.pkt_done), 64'(0));
    chk("rst_err", 64'(bus.err_switch), 64'(0));
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bit acc;
    int i;
    int len;
    logic [1:0] id;
    logic [1:0] wid;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_id     = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 4'b0000;
    rand_rdy      = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();
    idle(1);

    // Single-word TLP to channel 2
    send_word(2'd2, 32'hA5, 1'b1);
    chk("t1_valid", 64'(bus.out_valid[2]), 64'(1));
    chk("t1_data", 64'(bus.out_data[2*DATA_W +: DATA_W]), 64'hA5);
    chk("t1_last", 64'(bus.out_last[2]), 64'(1));
    bus.out_ready = 4'b0100;
    step(acc);
    chk("t1_done", 64'(bus.pkt_done[2]), 64'(1));
    step(acc);
    chk("t1_done_clr", 64'(bus.pkt_done[2]), 64'(0));

    // Id switches mid-TLP: word stays on channel 1, error is sticky
    bus.out_ready = 4'b0000;
    send_word(2'd1, 32'h11, 1'b0);
    send_word(2'd3, 32'h12, 1'b0);
    send_word(2'd1, 32'h13, 1'b1);
    chk("t2_err", 64'(bus.err_switch), 64'(1));
    chk("t2_ch3_empty", 64'(bus.out_valid[3]), 64'(0));
    bus.out_ready = 4'b1111;
    idle(6);
    chk("t2_err_sticky", 64'(bus.err_switch), 64'(1));

    // Fill channel 0 with a 10-word TLP while its consumer stalls
    bus.out_ready = 4'b0000;
    i = 0;
    for (int k = 0; k < 11; k++) begin
      bus.in_valid = 1'b1;
      bus.in_id    = 2'd0;
      bus.in_data  = 32'h300 + 32'(i);
      bus.in_last  = (i == 9);
      step(acc);
      if (acc) i++;
    end
    chk("t3_stalled", 64'(bus.in_ready), 64'(0));

    // Pop with a push offered while full: push refused, then accepted next cycle
    bus.out_ready = 4'b0001;
    bus.in_data   = 32'h300 + 32'(i);
    bus.in_last   = (i == 9);
    step(acc);
    if (acc) i++;
    chk("t4_ready_after_pop", 64'(bus.in_ready), 64'(1));
    bus.out_ready = 4'b0000;
    bus.in_data   = 32'h300 + 32'(i);
    bus.in_last   = (i == 9);
    step(acc);
    if (acc) i++;
    chk("t4_full_again", 64'(bus.in_ready), 64'(0));

    bus.out_ready = 4'b1111;
    while (i < 10) begin
      send_word(2'd0, 32'h300 + 32'(i), (i == 9));
      i++;
    end
    send_word(2'd3, 32'h3A, 1'b0);
    send_word(2'd3, 32'h3B, 1'b1);
    idle(14);

    // Reset in the middle of a TLP with buffered words
    bus.out_ready = 4'b0000;
    send_word(2'd2, 32'h60, 1'b1);
    send_word(2'd1, 32'h61, 1'b0);
    do_reset();
    send_word(2'd3, 32'h66, 1'b1);
    chk("t6_route", 64'(bus.out_valid[3]), 64'(1));
    chk("t6_ch1_empty", 64'(bus.out_valid[1]), 64'(0));
    bus.out_ready = 4'b1111;
    idle(3);

    // Interleaved random TLPs under random backpressure
    rand_rdy = 1'b1;
    for (int t = 0; t < 80; t++) begin
      id  = 2'($urandom);
      len = int'($urandom_range(1, 4));
      for (int w = 0; w < len; w++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        wid = (w > 0 && $urandom_range(0, 7) == 0) ? 2'($urandom) : id;
        send_word(wid, $urandom, (w == len - 1));
      end
    end
    rand_rdy      = 1'b0;
    bus.out_ready = 4'b1111;
    idle(4 * DEPTH + 4);
    for (int c = 0; c < 4; c++) begin
      chk("pkt_done_count", 64'(seen[c]), 64'(sent[c]));
      chk("drained", 64'(bus.out_valid[c]), 64'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
